// File: rtl/mac_cfg_pkg.sv
// Shared constants for the MAC configuration slave: register map, COMMAND_CONFIG bits,
// reset values and the Avalon FSM state type. Optional error counter: MAC_CFG_ERR_CNT_EN.
package mac_cfg_pkg;

  localparam logic [9:0] ADDR_REV      = 10'h000;
  localparam logic [9:0] ADDR_SCRATCH  = 10'h001;
  localparam logic [9:0] ADDR_CMD      = 10'h002;
  localparam logic [9:0] ADDR_MAC0     = 10'h003;
  localparam logic [9:0] ADDR_MAC1     = 10'h004;
  localparam logic [9:0] ADDR_FRM_LEN  = 10'h005;
`ifdef MAC_CFG_ERR_CNT_EN
  localparam logic [9:0] ADDR_ERR_CNT  = 10'h03A;
  localparam logic [9:0] ADDR_ERR_CLR  = 10'h03B;
`endif

  localparam int CMD_TX_ENA_BIT   = 0;
  localparam int CMD_RX_ENA_BIT   = 1;
  localparam int CMD_SW_RESET_BIT = 13;

  localparam logic [13:0] FRM_LENGTH_RST = 14'd1518;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  function automatic logic is_mapped(input logic [9:0] addr);
    logic hit;
    hit = (addr <= ADDR_FRM_LEN);
`ifdef MAC_CFG_ERR_CNT_EN
    hit = hit | (addr == ADDR_ERR_CNT) | (addr == ADDR_ERR_CLR);
`endif
    return hit;
  endfunction

endpackage

// File: rtl/mac_cfg_regs.sv
// Register bank and software-reset timer of the MAC configuration slave.
// With MAC_CFG_ERR_CNT_EN defined, also a saturating error counter at 0x03A.
module mac_cfg_regs #(
  parameter int          SWRST_CYCLES = 8,
  parameter logic [31:0] REV_ID       = 32'h0000_0901
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        acc_en,
  input  logic        wr_en,
  input  logic        coll,
  input  logic [9:0]  acc_addr,
  input  logic [31:0] wr_data,
  input  logic [9:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        tx_ena,
  output logic        rx_ena,
  output logic [47:0] mac_addr,
  output logic [13:0] frm_length,
  output logic        mac_sw_reset
);
  import mac_cfg_pkg::*;

  logic [31:0] scratch_q, scratch_d;
  logic        tx_q, tx_d;
  logic        rx_q, rx_d;
  logic [31:0] mac0_q, mac0_d;
  logic [15:0] mac1_q, mac1_d;
  logic [13:0] frm_q, frm_d;
  logic [7:0]  swrst_cnt_q, swrst_cnt_d;
  logic        sw_active;

  assign sw_active = (swrst_cnt_q != 8'd0);

  always_comb begin
    scratch_d   = scratch_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    mac0_d      = mac0_q;
    mac1_d      = mac1_q;
    frm_d       = frm_q;
    swrst_cnt_d = sw_active ? swrst_cnt_q - 8'd1 : 8'd0;
    if (wr_en) begin
      case (acc_addr)
        ADDR_SCRATCH: scratch_d = wr_data;
        ADDR_CMD: begin
          // COMMAND_CONFIG is locked while a software reset is in progress
          if (!sw_active) begin
            if (wr_data[CMD_SW_RESET_BIT]) begin
              tx_d        = 1'b0;
              rx_d        = 1'b0;
              swrst_cnt_d = 8'(SWRST_CYCLES);
            end else begin
              tx_d = wr_data[CMD_TX_ENA_BIT];
              rx_d = wr_data[CMD_RX_ENA_BIT];
            end
          end
        end
        ADDR_MAC0:    mac0_d = wr_data;
        ADDR_MAC1:    mac1_d = wr_data[15:0];
        ADDR_FRM_LEN: frm_d  = wr_data[13:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scratch_q   <= '0;
      tx_q        <= 1'b0;
      rx_q        <= 1'b0;
      mac0_q      <= '0;
      mac1_q      <= '0;
      frm_q       <= FRM_LENGTH_RST;
      swrst_cnt_q <= '0;
    end else begin
      scratch_q   <= scratch_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      mac0_q      <= mac0_d;
      mac1_q      <= mac1_d;
      frm_q       <= frm_d;
      swrst_cnt_q <= swrst_cnt_d;
    end
  end

`ifdef MAC_CFG_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (acc_en && (coll || !is_mapped(acc_addr)) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
    if (wr_en && (acc_addr == ADDR_ERR_CLR)) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end
`else
  logic unused_err_inputs;
  assign unused_err_inputs = acc_en ^ coll;
`endif

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_REV:     rd_data = REV_ID;
      ADDR_SCRATCH: rd_data = scratch_q;
      ADDR_CMD:     rd_data = {18'd0, sw_active, 11'd0, rx_q, tx_q};
      ADDR_MAC0:    rd_data = mac0_q;
      ADDR_MAC1:    rd_data = {16'd0, mac1_q};
      ADDR_FRM_LEN: rd_data = {18'd0, frm_q};
`ifdef MAC_CFG_ERR_CNT_EN
      ADDR_ERR_CNT: rd_data = {16'd0, err_cnt_q};
`endif
      default:      rd_data = '0;
    endcase
  end

  assign tx_ena       = tx_q & ~sw_active;
  assign rx_ena       = rx_q & ~sw_active;
  assign mac_addr     = {mac1_q, mac0_q};
  assign frm_length   = frm_q;
  assign mac_sw_reset = sw_active;

endmodule

// File: rtl/mac_cfg_slave.sv
// Avalon-MM configuration slave for a MAC: access FSM with wait states in front of
// the register bank. Optional error counter: MAC_CFG_ERR_CNT_EN.
module mac_cfg_slave #(
  parameter int          WAIT_CYCLES  = 2,
  parameter int          SWRST_CYCLES = 8,
  parameter logic [31:0] REV_ID       = 32'h0000_0901
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        read,
  input  logic        write,
  output logic        waitrequest,
  output logic        tx_ena,
  output logic        rx_ena,
  output logic [47:0] mac_addr,
  output logic [13:0] frm_length,
  output logic        mac_sw_reset
);
  import mac_cfg_pkg::*;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        coll_q, coll_d;
  logic [31:0] readdata_q, readdata_d;

  logic [9:0]  rd_addr;
  logic        rd_go;
  logic [31:0] rd_data;
  logic        acc_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    coll_d  = coll_q;
    case (state_q)
      ST_IDLE: begin
        if (read || write) begin
          addr_d  = address;
          wdata_d = writedata;
          rd_d    = read;
          wr_d    = write & ~read;  // a read wins a collision
          coll_d  = read & write;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Zero-wait accesses leave IDLE straight into ACK, so read from the live bus there.
  assign rd_addr = (state_q == ST_IDLE) ? address : addr_q;
  assign rd_go   = (state_q == ST_IDLE) ? read : rd_q;

  always_comb begin
    readdata_d = '0;
    if ((state_d == ST_ACK) && rd_go) begin
      readdata_d = rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      coll_q     <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      coll_q     <= coll_d;
      readdata_q <= readdata_d;
    end
  end

  assign acc_en      = (state_q == ST_ACK);
  assign waitrequest = (state_q != ST_ACK);
  assign readdata    = readdata_q;

  mac_cfg_regs #(
    .SWRST_CYCLES (SWRST_CYCLES),
    .REV_ID       (REV_ID)
  ) u_regs (
    .clk          (clk),
    .reset_n      (reset_n),
    .acc_en       (acc_en),
    .wr_en        (acc_en & wr_q),
    .coll         (coll_q),
    .acc_addr     (addr_q),
    .wr_data      (wdata_q),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .tx_ena       (tx_ena),
    .rx_ena       (rx_ena),
    .mac_addr     (mac_addr),
    .frm_length   (frm_length),
    .mac_sw_reset (mac_sw_reset)
  );

endmodule

// File: tb/tb_mac_cfg_slave.sv
// Scoreboard bench for mac_cfg_slave: stimulus queues expectations, a monitor
// process compares read data, access latency and sampled status outputs.
module tb_mac_cfg_slave;

  localparam int WAIT_CYCLES = 2;
  localparam int ACC_CYCLES  = 4;  // 2 + WAIT_CYCLES

  localparam int SEL_TX    = 0;
  localparam int SEL_RX    = 1;
  localparam int SEL_MAC   = 2;
  localparam int SEL_FRM   = 3;
  localparam int SEL_SWR   = 4;
  localparam int SEL_WREQ  = 5;
  localparam int SEL_RDATA = 6;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } chk_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  address = '0;
  logic [31:0] writedata = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        tx_ena;
  logic        rx_ena;
  logic [47:0] mac_addr;
  logic [13:0] frm_length;
  logic        mac_sw_reset;

  chk_t chk_q[$];
  rd_t  rd_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mac_cfg_slave #(
    .WAIT_CYCLES  (WAIT_CYCLES),
    .SWRST_CYCLES (8),
    .REV_ID       (32'h0000_0901)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .read         (read),
    .write        (write),
    .waitrequest  (waitrequest),
    .tx_ena       (tx_ena),
    .rx_ena       (rx_ena),
    .mac_addr     (mac_addr),
    .frm_length   (frm_length),
    .mac_sw_reset (mac_sw_reset)
  );

  function automatic logic [63:0] sample(input int sel);
    case (sel)
      SEL_TX:    return {63'd0, tx_ena};
      SEL_RX:    return {63'd0, rx_ena};
      SEL_MAC:   return {16'd0, mac_addr};
      SEL_FRM:   return {50'd0, frm_length};
      SEL_SWR:   return {63'd0, mac_sw_reset};
      SEL_WREQ:  return {63'd0, waitrequest};
      SEL_RDATA: return {32'd0, readdata};
      default:   return '0;
    endcase
  endfunction

  task automatic expect_sig(input string n, input int sel, input logic [63:0] e);
    chk_t c;
    c.name = n;
    c.sel  = sel;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic r, input logic w, input logic [9:0] a,
                        input logic [31:0] d, input string n, input logic [31:0] rexp);
    bit  done;
    rd_t e;
    done = 1'b0;
    if (r) begin
      e.name = n;
      e.exp  = rexp;
      rd_q.push_back(e);
    end
    read      = r;
    write     = w;
    address   = a;
    writedata = d;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!waitrequest) done = 1'b1;
    end
    if (!done) expect_sig({n, "_timeout"}, SEL_WREQ, 64'd0);
    @(posedge clk);
    #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    access(1'b0, 1'b1, a, d, "wr", 32'd0);
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] e, input string n);
    access(1'b1, 1'b0, a, 32'd0, n, e);
  endtask

  // Monitor: the only process that updates the check/error counters.
  initial begin
    int          cyc;
    bit          in_acc;
    rd_t         e;
    chk_t        c;
    logic [63:0] act;
    cyc    = 0;
    in_acc = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_acc = 1'b0;
      end else if (read || write) begin
        if (!in_acc) begin
          in_acc = 1'b1;
          cyc    = 1;
        end else begin
          cyc++;
        end
        if (!waitrequest) begin
          checks++;
          if (cyc != ACC_CYCLES) begin
            errors++;
            $display("FAIL latency addr 0x%03h: got %0d cycles, expected %0d", address, cyc, ACC_CYCLES);
          end
          if (read) begin
            checks++;
            if (rd_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_read addr 0x%03h: got 0x%08h, expected no read", address, readdata);
            end else begin
              e = rd_q.pop_front();
              if (readdata !== e.exp) begin
                errors++;
                $display("FAIL %s addr 0x%03h: got 0x%08h, expected 0x%08h", e.name, address, readdata, e.exp);
              end else begin
                $display("read  %-20s addr 0x%03h data 0x%08h cycles %0d", e.name, address, readdata, cyc);
              end
            end
          end else begin
            $display("write addr 0x%03h data 0x%08h cycles %0d", address, writedata, cyc);
          end
          in_acc = 1'b0;
        end
      end
      while (chk_q.size() > 0) begin
        c   = chk_q.pop_front();
        act = sample(c.sel);
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h", c.name, act, c.exp);
        end else begin
          $display("check %-20s value 0x%0h", c.name, act);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) step();
    expect_sig("rst_waitrequest", SEL_WREQ, 64'd1);
    expect_sig("rst_readdata", SEL_RDATA, 64'd0);
    expect_sig("rst_frm_length", SEL_FRM, 64'd1518);
    expect_sig("rst_sw_reset", SEL_SWR, 64'd0);
    expect_sig("rst_tx_ena", SEL_TX, 64'd0);
    expect_sig("rst_mac_addr", SEL_MAC, 64'd0);
    step();
    reset_n = 1'b1;
    step();

    rd(10'h000, 32'h0000_0901, "rev");
    rd(10'h005, 32'd1518, "frm_len_rst");
    wr(10'h001, 32'h1234_5678);
    rd(10'h001, 32'h1234_5678, "scratch");

    wr(10'h002, 32'h0000_0003);
    wr(10'h003, 32'hAABB_CCDD);
    wr(10'h004, 32'h0000_1122);
    expect_sig("tx_ena_on", SEL_TX, 64'd1);
    expect_sig("rx_ena_on", SEL_RX, 64'd1);
    expect_sig("mac_addr", SEL_MAC, 64'h0000_1122_AABB_CCDD);
    rd(10'h004, 32'h0000_1122, "mac1");
    rd(10'h002, 32'h0000_0003, "cmd");

    rd(10'h3FF, 32'd0, "unmapped");
    wr(10'h3FF, 32'hFFFF_FFFF);
    rd(10'h001, 32'h1234_5678, "scratch_after_unm");
    expect_sig("mac_after_unm", SEL_MAC, 64'h0000_1122_AABB_CCDD);
    expect_sig("frm_after_unm", SEL_FRM, 64'd1518);

    wr(10'h005, 32'hFFFF_FFFF);
    expect_sig("frm_mask", SEL_FRM, 64'h3FFF);
    rd(10'h005, 32'h0000_3FFF, "frm_len_mask");

    access(1'b1, 1'b1, 10'h001, 32'hDEAD_BEEF, "collision", 32'h1234_5678);
    rd(10'h001, 32'h1234_5678, "scratch_after_coll");

    // Software reset pulse: cycle 1 of 8 is the cycle after the commit edge
    wr(10'h002, 32'h0000_2003);
    expect_sig("swr_c1", SEL_SWR, 64'd1);
    expect_sig("swr_c1_tx", SEL_TX, 64'd0);
    wr(10'h002, 32'h0000_0003);
    expect_sig("swr_c5", SEL_SWR, 64'd1);
    expect_sig("swr_c5_tx", SEL_TX, 64'd0);
    expect_sig("swr_c5_rx", SEL_RX, 64'd0);
    repeat (3) step();
    expect_sig("swr_c8", SEL_SWR, 64'd1);
    step();
    expect_sig("swr_c9", SEL_SWR, 64'd0);
    expect_sig("swr_c9_tx", SEL_TX, 64'd0);
    expect_sig("swr_c9_rx", SEL_RX, 64'd0);
    rd(10'h002, 32'd0, "cmd_after_swr");

    wr(10'h002, 32'h0000_2000);
    rd(10'h002, 32'h0000_2000, "cmd_bit13");
    repeat (8) step();
    expect_sig("swr2_done", SEL_SWR, 64'd0);

    // Reset during the wait phase of a write aborts it
    address   = 10'h001;
    writedata = 32'h0000_CAFE;
    write     = 1'b1;
    step();
    reset_n = 1'b0;
    step();
    write   = 1'b0;
    reset_n = 1'b1;
    expect_sig("abort_waitrequest", SEL_WREQ, 64'd1);
    step();
    rd(10'h001, 32'd0, "scratch_after_abort");
    expect_sig("abort_frm_rst", SEL_FRM, 64'd1518);

`ifdef MAC_CFG_ERR_CNT_EN
    wr(10'h03B, 32'd0);
    rd(10'h3FF, 32'd0, "unmapped_a");
    rd(10'h200, 32'd0, "unmapped_b");
    rd(10'h03A, 32'd2, "err_cnt");
    wr(10'h03B, 32'h1234);
    rd(10'h03A, 32'd0, "err_cnt_cleared");
`else
    rd(10'h03A, 32'd0, "err_cnt_unmapped");
    wr(10'h03B, 32'hFFFF_FFFF);
    rd(10'h03B, 32'd0, "err_clr_unmapped");
`endif

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
